instr_fetch: RTL

- Instruction fetch unit for the multicycle MIPS core. It drives the instruction-side memory bus (Avalon-style read master with waitrequest) and holds the program counter.
- It presents each fetched word, with its PC, to the instruction register and decode stage through a valid/ready handshake.
- It applies MIPS branch-delay-slot redirect semantics and the halt-on-jump-to-zero convention.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_pc_next.sv | 26 ++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    // 32-bit machine word, used for addresses and instruction data.
    typedef logic [31:0] size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam size_t RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam size_t HALT_ADDR_DEFAULT    = 32'h00000000;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection with branch-delay-slot semantics. Purely combinational.
module instr_fetch_pc_next
    import instr_fetch_pkg::*;
#(
    parameter size_t HALT_ADDR = HALT_ADDR_DEFAULT
) (
    input  size_t pc,
    input  logic  pending,
    input  size_t pending_target,
    input  logic  redirect_valid,
    output size_t next_pc,
    output logic  set_pending,
    output logic  halt,
    output logic  fault
);

    // A pending redirect wins: the instruction being accepted is the delay
    // slot, so any redirect it carries is dropped. Otherwise fall through.
    always_comb begin
        next_pc     = pending ? pending_target : pc + 32'd4;
        set_pending = !pending && redirect_valid;
        halt        = (next_pc == HALT_ADDR);
        fault       = !halt && (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: Avalon read master plus PC, valid/ready output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter size_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter size_t HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_i,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic [3:0]  avm_byteenable_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic        active_o,
    output logic        fault_o
);

    fetch_state_t state, state_d;
    size_t        pc, pc_d;
    size_t        pending_target;
    logic         pending, pending_d;
    logic         target_load;

    size_t        addr_d, instr_d, pc_out_d;
    logic         read_d, valid_d, active_d, fault_d;

    size_t        next_pc;
    logic         set_pending, next_halt, next_fault;

    instr_fetch_pc_next #(
        .HALT_ADDR (HALT_ADDR)
    ) u_pc_next (
        .pc             (pc),
        .pending        (pending),
        .pending_target (pending_target),
        .redirect_valid (redirect_valid_i),
        .next_pc        (next_pc),
        .set_pending    (set_pending),
        .halt           (next_halt),
        .fault          (next_fault)
    );

    assign avm_byteenable_o = avm_read_o ? 4'b1111 : 4'b0000;

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        read_d      = avm_read_o;
        addr_d      = avm_address_o;
        instr_d     = instr_o;
        pc_out_d    = pc_o;
        valid_d     = instr_valid_o;
        pending_d   = pending;
        target_load = 1'b0;
        active_d    = active_o;
        fault_d     = fault_o;

        case (state)
            IDLE: begin
                read_d  = 1'b1;
                addr_d  = pc;
                state_d = REQ;
            end
            REQ: begin
                if (!avm_waitrequest_i) begin
                    instr_d  = avm_readdata_i;
                    pc_out_d = pc;
                    valid_d  = 1'b1;
                    read_d   = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    valid_d = 1'b0;
                    if (pending) begin
                        pending_d = 1'b0;
                    end else if (set_pending) begin
                        pending_d   = 1'b1;
                        target_load = 1'b1;
                    end
                    if (next_halt) begin
                        state_d  = HALTED;
                        active_d = 1'b0;
                    end else if (next_fault) begin
                        state_d  = HALTED;
                        active_d = 1'b0;
                        fault_d  = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        read_d  = 1'b1;
                        addr_d  = next_pc;
                        state_d = REQ;
                    end
                end
            end
            HALTED: begin
                read_d  = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            avm_read_o    <= 1'b0;
            avm_address_o <= RESET_VECTOR;
            instr_o       <= '0;
            pc_o          <= '0;
            instr_valid_o <= 1'b0;
            pending       <= 1'b0;
            active_o      <= 1'b1;
            fault_o       <= 1'b0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            avm_read_o    <= read_d;
            avm_address_o <= addr_d;
            instr_o       <= instr_d;
            pc_o          <= pc_out_d;
            instr_valid_o <= valid_d;
            pending       <= pending_d;
            active_o      <= active_d;
            fault_o       <= fault_d;
        end
    end

    // Redirect target is only meaningful while pending=1, so it needs no reset.
    always_ff @(posedge clk) begin
        if (target_load) begin
            pending_target <= redirect_target_i;
        end
    end

endmodule
